div4_stream_scheduler: RTL

Shares one serial mod-4 residue engine among `N_REQ` requesters that each present a parallel word. Round-robin arbitration picks one requester, accepts its word, and shifts the word MSB-first through the engine, one bit per cycle. It then returns the residue and a divisible-by-4 flag on a valid/ready response port, tagged with the requester index. The block sits between parallel producers and the bit-serial divisibility detector and is that detector's only sequencer.

---
 rtl/div4_pkg.sv | 32 +++
 rtl/serial_mod4_core.sv | 22 ++
 rtl/div4_stream_scheduler.sv | 110 +++++++++++
 3 files changed

// File: rtl/div4_pkg.sv
// Shared types and helpers for the mod-4 stream scheduler and its bit-serial engine.
package div4_pkg;

    localparam int REM_W   = 2;
    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Bits above the real requester count are zero, so wrapping at 16 yields the
    // same first-set order as wrapping at N_REQ.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [3:0]         ptr);
        logic [3:0] pick;
        logic [3:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + 4'(k);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/serial_mod4_core.sv
// Bit-serial residue engine: folds one bit per enabled cycle, MSB first, into r mod 4.
module serial_mod4_core
    import div4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [REM_W-1:0] rem
);

    // (2*r + bit) mod 4 keeps only the old low bit and the new bit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rem <= '0;
        end else if (en) begin
            rem <= {rem[0], bit_in};
        end
    end

endmodule

// File: rtl/div4_stream_scheduler.sv
// Round-robin sequencer that shares one serial mod-4 engine among N_REQ parallel requesters
// and returns residue/div4 results tagged with the requester index.
module div4_stream_scheduler
    import div4_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [REM_W-1:0]       resp_rem,
    output logic                   resp_div4,
    output logic                   busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [3:0]        grant;
    logic              any_req;
    logic              accept;
    logic [WIDTH-1:0]  grant_word;
    logic [ID_W-1:0]   next_ptr;
    logic [REM_W-1:0]  rem;

    assign any_req = |req_valid;
    assign grant   = rr_pick(16'(req_valid), 4'(rr_ptr));
    assign accept  = (state == IDLE) && !rst && any_req;

    always_comb begin
        req_ready  = '0;
        grant_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == 4'(i)) begin
                req_ready[i] = accept;
                grant_word   = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        next_ptr = '0;
        if (grant != 4'(N_REQ - 1)) begin
            next_ptr = ID_W'(grant + 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            resp_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= grant_word;
                        bit_cnt <= '0;
                        resp_id <= ID_W'(grant);
                        rr_ptr  <= next_ptr;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The engine is cleared on accept and frozen outside SHIFT, so its residue
    // stays stable for the whole DONE hold.
    serial_mod4_core u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state == SHIFT),
        .bit_in (shreg[WIDTH-1]),
        .rem    (rem)
    );

    assign resp_valid = (state == DONE);
    assign resp_rem   = rem;
    assign resp_div4  = (state == DONE) && (rem == '0);
    assign busy       = (state != IDLE);

endmodule
